// File: rtl/sysid_access_arbiter_if.sv
// sysid_access_arbiter_if: requester, sys_id slave and ID-check signals of the arbiter
interface sysid_access_arbiter_if;
  logic m0_read;
  logic m0_address;
  logic m0_waitrequest;
  logic m0_readdatavalid;
  logic [31:0] m0_readdata;
  logic m1_read;
  logic m1_address;
  logic m1_waitrequest;
  logic m1_readdatavalid;
  logic [31:0] m1_readdata;
  logic sid_address;
  logic [31:0] sid_readdata;
  logic check_start;
  logic check_busy;
  logic check_done;
  logic check_pass;
  logic [31:0] check_id;
  logic [31:0] check_ts;
  modport master (
    output m0_read, m0_address, m1_read, m1_address, sid_readdata, check_start,
    input m0_waitrequest, m0_readdatavalid, m0_readdata,
    input m1_waitrequest, m1_readdatavalid, m1_readdata,
    input sid_address, check_busy, check_done, check_pass, check_id, check_ts
  );
  modport slave (
    input m0_read, m0_address, m1_read, m1_address, sid_readdata, check_start,
    output m0_waitrequest, m0_readdatavalid, m0_readdata,
    output m1_waitrequest, m1_readdatavalid, m1_readdata,
    output sid_address, check_busy, check_done, check_pass, check_id, check_ts
  );
endinterface

// File: rtl/sysid_access_arbiter.sv
// sysid_access_arbiter: shares the sys_id slave between two requesters and an ID-check sequencer
module sysid_access_arbiter #(
  parameter int READ_LATENCY = 0,
  parameter logic [31:0] EXPECTED_ID = 32'h0400_0000,
  parameter logic [31:0] EXPECTED_TS = 32'h545A_70F2,
  parameter bit AUTO_CHECK = 1'b1
) (
  input logic clock,
  input logic reset,
  sysid_access_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
  typedef enum logic [1:0] {OWN_M0, OWN_M1, OWN_CHK} owner_t;
  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  state_t state, state_n;
  owner_t owner;
  logic pending, last_grant, addr, free, grant0, grant1, busy, start_ok;
  logic [2:0] cnt;
  logic [31:0] data_reg;
  always_comb begin
    free = state == IDLE && !pending && !reset;
    grant0 = free && bus.m0_read && (!bus.m1_read || last_grant);
    grant1 = free && bus.m1_read && (!bus.m0_read || !last_grant);
    busy = pending || (state != IDLE && owner == OWN_CHK);
    start_ok = bus.check_start && !busy;
    state_n = state == IDLE ? ((pending || grant0 || grant1) ? ACCESS : IDLE)
            : state == ACCESS ? (cnt == 3'd0 ? RESPOND : ACCESS)
            : (owner == OWN_CHK && !addr) ? ACCESS : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= AUTO_CHECK;
      last_grant <= 1'b1;
      owner <= OWN_M0;
      addr <= 1'b0;
      cnt <= 3'd0;
      data_reg <= '0;
      bus.m0_readdata <= '0;
      bus.m1_readdata <= '0;
      bus.check_done <= 1'b0;
      bus.check_pass <= 1'b0;
      bus.check_id <= '0;
      bus.check_ts <= '0;
    end else begin
      if (state == IDLE && pending) begin
        owner <= OWN_CHK;
        addr <= 1'b0;
        pending <= 1'b0;
        cnt <= LAT;
      end else if (grant0 || grant1) begin
        owner <= grant1 ? OWN_M1 : OWN_M0;
        addr <= grant1 ? bus.m1_address : bus.m0_address;
        last_grant <= grant1;
        cnt <= LAT;
      end
      if (state == ACCESS) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd0) begin
          data_reg <= bus.sid_readdata;
          if (owner == OWN_M0) bus.m0_readdata <= bus.sid_readdata;
          if (owner == OWN_M1) bus.m1_readdata <= bus.sid_readdata;
        end
      end
      if (state == RESPOND && owner == OWN_CHK) begin
        if (!addr) begin
          bus.check_id <= data_reg;
          addr <= 1'b1;
          cnt <= LAT;
        end else begin
          bus.check_ts <= data_reg;
          bus.check_pass <= (bus.check_id == EXPECTED_ID) && (data_reg == EXPECTED_TS);
          bus.check_done <= 1'b1;
        end
      end
      if (start_ok) begin
        pending <= 1'b1;
        bus.check_done <= 1'b0;
        bus.check_pass <= 1'b0;
      end
    end
  end
  assign bus.m0_waitrequest = !grant0;
  assign bus.m1_waitrequest = !grant1;
  assign bus.m0_readdatavalid = state == RESPOND && owner == OWN_M0;
  assign bus.m1_readdatavalid = state == RESPOND && owner == OWN_M1;
  assign bus.sid_address = addr;
  assign bus.check_busy = busy;
endmodule

// File: tb/tb_sysid_access_arbiter.sv
// tb_sysid_access_arbiter: self-checking bench with a transaction-level arbitration model
module tb_sysid_access_arbiter;
  localparam logic [31:0] ID = 32'h0400_0000;
  localparam logic [31:0] TS = 32'h545A_70F2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] slv_ts = TS;
  logic [2:0] hist = 3'd0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_win = 1;
  sysid_access_arbiter_if a();
  sysid_access_arbiter_if b();
  sysid_access_arbiter #(.READ_LATENCY(0)) u_dut0 (.clock(clk), .reset(rst), .bus(a));
  sysid_access_arbiter #(.READ_LATENCY(3)) u_dut3 (.clock(clk), .reset(rst), .bus(b));
  always #5 clk = ~clk;
  assign a.sid_readdata = a.sid_address ? slv_ts : ID;
  always @(posedge clk) hist <= {hist[1:0], b.sid_address};
  assign b.sid_readdata = hist[2] ? slv_ts : ID;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    a.m0_read = 1'b1; a.m0_address = 1'b0; a.m1_read = 1'b0; a.m1_address = 1'b0; a.check_start = 1'b0;
    b.m0_read = 1'b0; b.m0_address = 1'b0; b.m1_read = 1'b0; b.m1_address = 1'b0; b.check_start = 1'b0;
    tick();
    tick();
    #1;
    n_cmp++; if (a.m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset m0_waitrequest: got %b expected 1", a.m0_waitrequest); end
    n_cmp++; if (a.m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset m1_waitrequest: got %b expected 1", a.m1_waitrequest); end
    n_cmp++; if (a.m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL reset m0_readdatavalid: got %b expected 0", a.m0_readdatavalid); end
    n_cmp++; if (a.m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL reset m1_readdatavalid: got %b expected 0", a.m1_readdatavalid); end
    n_cmp++; if (a.m0_readdata !== 32'h0) begin n_err++; $display("FAIL reset m0_readdata: got %h expected 0", a.m0_readdata); end
    n_cmp++; if (a.m1_readdata !== 32'h0) begin n_err++; $display("FAIL reset m1_readdata: got %h expected 0", a.m1_readdata); end
    n_cmp++; if (a.sid_address !== 1'b0) begin n_err++; $display("FAIL reset sid_address: got %b expected 0", a.sid_address); end
    n_cmp++; if (a.check_done !== 1'b0) begin n_err++; $display("FAIL reset check_done: got %b expected 0", a.check_done); end
    n_cmp++; if (a.check_pass !== 1'b0) begin n_err++; $display("FAIL reset check_pass: got %b expected 0", a.check_pass); end
    n_cmp++; if (a.check_id !== 32'h0) begin n_err++; $display("FAIL reset check_id: got %h expected 0", a.check_id); end
    n_cmp++; if (a.check_ts !== 32'h0) begin n_err++; $display("FAIL reset check_ts: got %h expected 0", a.check_ts); end
    n_cmp++; if (a.check_busy !== 1'b1) begin n_err++; $display("FAIL reset check_busy: got %b expected 1", a.check_busy); end
    a.m0_read = 1'b0;
    last_win = 1;
  endtask
  task automatic test_auto_check();
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) begin
        n_cmp++; if (a.sid_address !== 1'b0) begin n_err++; $display("FAIL auto sid_address word0: got %b expected 0", a.sid_address); end
        n_cmp++; if (a.check_busy !== 1'b1) begin n_err++; $display("FAIL auto check_busy: got %b expected 1", a.check_busy); end
      end
      if (k == 3) begin
        n_cmp++; if (a.sid_address !== 1'b1) begin n_err++; $display("FAIL auto sid_address word1: got %b expected 1", a.sid_address); end
        n_cmp++; if (a.check_id !== ID) begin n_err++; $display("FAIL auto check_id: got %h expected %h", a.check_id, ID); end
      end
      if (k == 4) begin
        n_cmp++; if (a.check_done !== 1'b0) begin n_err++; $display("FAIL auto early check_done: got %b expected 0", a.check_done); end
      end
      if (k == 5) begin
        n_cmp++; if (a.check_done !== 1'b1) begin n_err++; $display("FAIL auto check_done: got %b expected 1", a.check_done); end
        n_cmp++; if (a.check_pass !== 1'b1) begin n_err++; $display("FAIL auto check_pass: got %b expected 1", a.check_pass); end
        n_cmp++; if (a.check_ts !== TS) begin n_err++; $display("FAIL auto check_ts: got %h expected %h", a.check_ts, TS); end
        n_cmp++; if (a.check_busy !== 1'b0) begin n_err++; $display("FAIL auto busy after: got %b expected 0", a.check_busy); end
      end
      if (k == 10) begin
        n_cmp++; if (b.check_done !== 1'b0) begin n_err++; $display("FAIL auto L3 early check_done: got %b expected 0", b.check_done); end
      end
      if (k == 11) begin
        n_cmp++; if (b.check_done !== 1'b1) begin n_err++; $display("FAIL auto L3 check_done: got %b expected 1", b.check_done); end
        n_cmp++; if (b.check_pass !== 1'b1) begin n_err++; $display("FAIL auto L3 check_pass: got %b expected 1", b.check_pass); end
      end
    end
  endtask
  task automatic test_single();
    a.m0_read = 1'b1;
    a.m0_address = 1'b1;
    #1;
    n_cmp++; if (a.m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL single m0_waitrequest: got %b expected 0", a.m0_waitrequest); end
    n_cmp++; if (a.m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL single m1_waitrequest: got %b expected 1", a.m1_waitrequest); end
    last_win = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      a.m0_read = 1'b0;
      n_cmp++; if (a.m0_readdatavalid !== (k == 2)) begin n_err++; $display("FAIL single m0_readdatavalid k=%0d: got %b expected %b", k, a.m0_readdatavalid, k == 2); end
      if (k >= 2) begin
        n_cmp++; if (a.m0_readdata !== TS) begin n_err++; $display("FAIL single m0_readdata k=%0d: got %h expected %h", k, a.m0_readdata, TS); end
      end
      n_cmp++; if (a.m1_readdatavalid !== 1'b0 || a.m1_readdata !== 32'h0) begin n_err++; $display("FAIL single m1 untouched: got %b/%h expected 0/0", a.m1_readdatavalid, a.m1_readdata); end
    end
  endtask
  task automatic test_round_robin();
    int expw, grants, prev, g0, g1;
    int since[2];
    expw = 1 - last_win;
    grants = 0;
    prev = -1;
    since[0] = cyc;
    since[1] = cyc;
    a.m0_read = 1'b1; a.m0_address = 1'b0;
    a.m1_read = 1'b1; a.m1_address = 1'b1;
    for (int k = 0; k < 40 && grants < 8; k++) begin
      #1;
      g0 = a.m0_waitrequest === 1'b0 ? 1 : 0;
      g1 = a.m1_waitrequest === 1'b0 ? 1 : 0;
      if (g0 + g1 > 0) begin
        n_cmp++; if (g0 != (expw == 0 ? 1 : 0) || g1 != (expw == 1 ? 1 : 0)) begin n_err++; $display("FAIL rr winner: got m0=%0d m1=%0d expected m%0d", g0, g1, expw); end
        if (prev >= 0) begin
          n_cmp++; if (cyc - prev != 3) begin n_err++; $display("FAIL rr spacing: got %0d expected 3", cyc - prev); end
        end
        n_cmp++; if (cyc - since[expw] > 6) begin n_err++; $display("FAIL rr wait m%0d: got %0d expected <=6", expw, cyc - since[expw]); end
        since[expw] = cyc;
        prev = cyc;
        expw = 1 - expw;
        grants++;
      end
      tick();
    end
    n_cmp++; if (grants != 8) begin n_err++; $display("FAIL rr grants: got %0d expected 8", grants); end
    last_win = 1 - expw;
    a.m0_read = 1'b0;
    a.m1_read = 1'b0;
    repeat (3) tick();
  endtask
  task automatic test_latency();
    b.m1_read = 1'b1;
    b.m1_address = 1'b0;
    #1;
    n_cmp++; if (b.m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL lat m1_waitrequest: got %b expected 0", b.m1_waitrequest); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      b.m1_read = 1'b0;
      if (k < 5) begin
        n_cmp++; if (b.sid_address !== 1'b0) begin n_err++; $display("FAIL lat sid_address k=%0d: got %b expected 0", k, b.sid_address); end
        n_cmp++; if (b.m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL lat early valid k=%0d: got %b expected 0", k, b.m1_readdatavalid); end
      end else begin
        n_cmp++; if (b.m1_readdatavalid !== 1'b1) begin n_err++; $display("FAIL lat m1_readdatavalid: got %b expected 1", b.m1_readdatavalid); end
        n_cmp++; if (b.m1_readdata !== ID) begin n_err++; $display("FAIL lat m1_readdata: got %h expected %h", b.m1_readdata, ID); end
        n_cmp++; if (b.m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL lat m0_readdatavalid: got %b expected 0", b.m0_readdatavalid); end
      end
    end
    repeat (2) tick();
  endtask
  task automatic test_mismatch();
    slv_ts = TS + 32'd1;
    a.check_start = 1'b1;
    tick();
    a.check_start = 1'b0;
    n_cmp++; if (a.check_done !== 1'b0) begin n_err++; $display("FAIL mis done cleared: got %b expected 0", a.check_done); end
    n_cmp++; if (a.check_busy !== 1'b1) begin n_err++; $display("FAIL mis busy: got %b expected 1", a.check_busy); end
    tick();
    a.check_start = 1'b1;
    tick();
    a.check_start = 1'b0;
    for (int k = 0; k < 12 && a.check_done !== 1'b1; k++) tick();
    n_cmp++; if (a.check_done !== 1'b1) begin n_err++; $display("FAIL mis check_done timeout: got %b expected 1", a.check_done); end
    n_cmp++; if (a.check_pass !== 1'b0) begin n_err++; $display("FAIL mis check_pass: got %b expected 0", a.check_pass); end
    n_cmp++; if (a.check_ts !== TS + 32'd1) begin n_err++; $display("FAIL mis check_ts: got %h expected %h", a.check_ts, TS + 32'd1); end
    n_cmp++; if (a.check_id !== ID) begin n_err++; $display("FAIL mis check_id: got %h expected %h", a.check_id, ID); end
    repeat (8) tick();
    n_cmp++; if (a.check_done !== 1'b1 || a.check_busy !== 1'b0) begin n_err++; $display("FAIL ignored start: got done=%b busy=%b expected 1/0", a.check_done, a.check_busy); end
    slv_ts = TS;
  endtask
  task automatic test_collide();
    a.m0_read = 1'b1;
    a.m0_address = 1'b0;
    a.check_start = 1'b1;
    #1;
    n_cmp++; if (a.m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL collide m0 first: got %b expected 0", a.m0_waitrequest); end
    tick();
    a.m0_read = 1'b0;
    a.check_start = 1'b0;
    n_cmp++; if (a.check_busy !== 1'b1 || a.check_done !== 1'b0) begin n_err++; $display("FAIL collide pending: got busy=%b done=%b expected 1/0", a.check_busy, a.check_done); end
    tick();
    n_cmp++; if (a.m0_readdatavalid !== 1'b1 || a.m0_readdata !== ID) begin n_err++; $display("FAIL collide response: got %b/%h expected 1/%h", a.m0_readdatavalid, a.m0_readdata, ID); end
    tick();
    a.m0_read = 1'b1;
    #1;
    n_cmp++; if (a.m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL collide checker slot: got %b expected 1", a.m0_waitrequest); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      #1;
      n_cmp++; if (a.m0_waitrequest !== (k != 5)) begin n_err++; $display("FAIL collide m0 wait k=%0d: got %b expected %b", k, a.m0_waitrequest, k != 5); end
      n_cmp++; if (a.check_done !== (k == 5)) begin n_err++; $display("FAIL collide done k=%0d: got %b expected %b", k, a.check_done, k == 5); end
    end
    n_cmp++; if (a.check_pass !== 1'b1) begin n_err++; $display("FAIL collide pass: got %b expected 1", a.check_pass); end
    tick();
    a.m0_read = 1'b0;
    last_win = 0;
    repeat (3) tick();
  endtask
  task automatic test_random();
    int free_at, win, pport, pc;
    bit pv, v, hit;
    logic [31:0] pdata, d;
    logic [31:0] hold[2];
    bit known[2];
    bit r[2];
    bit ad[2];
    free_at = cyc;
    pv = 1'b0; pport = 0; pc = 0; pdata = '0;
    known = '{1'b0, 1'b0}; r = '{1'b0, 1'b0}; ad = '{1'b0, 1'b0};
    for (int i = 0; i < 406; i++) begin
      for (int p = 0; p < 2; p++) begin
        v = p == 1 ? a.m1_readdatavalid : a.m0_readdatavalid;
        d = p == 1 ? a.m1_readdata : a.m0_readdata;
        hit = pv && pport == p && pc == cyc;
        n_cmp++; if (v !== hit) begin n_err++; $display("FAIL rand m%0d_readdatavalid cyc=%0d: got %b expected %b", p, cyc, v, hit); end
        if (hit) begin hold[p] = pdata; known[p] = 1'b1; pv = 1'b0; end
        if (known[p]) begin
          n_cmp++; if (d !== hold[p]) begin n_err++; $display("FAIL rand m%0d_readdata cyc=%0d: got %h expected %h", p, cyc, d, hold[p]); end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (i >= 400) r[p] = 1'b0;
        else if (!r[p]) begin
          if ($urandom_range(2) == 0) begin r[p] = 1'b1; ad[p] = 1'($urandom_range(1)); end
        end else if ($urandom_range(15) == 0) r[p] = 1'b0;
      end
      a.m0_read = r[0]; a.m0_address = ad[0];
      a.m1_read = r[1]; a.m1_address = ad[1];
      #1;
      win = -1;
      if (cyc >= free_at) win = (r[0] && r[1]) ? 1 - last_win : r[0] ? 0 : r[1] ? 1 : -1;
      n_cmp++; if (a.m0_waitrequest !== (win != 0) || a.m1_waitrequest !== (win != 1)) begin n_err++; $display("FAIL rand grant cyc=%0d: got wr0=%b wr1=%b expected winner %0d", cyc, a.m0_waitrequest, a.m1_waitrequest, win); end
      if (win >= 0) begin
        free_at = cyc + 3;
        last_win = win;
        pv = 1'b1; pport = win; pc = cyc + 2;
        pdata = ad[win] ? slv_ts : ID;
        r[win] = 1'b0;
      end
      tick();
    end
  endtask
  task automatic test_reset_abort();
    a.m0_read = 1'b1;
    a.m0_address = 1'b1;
    #1;
    n_cmp++; if (a.m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL abort grant: got %b expected 0", a.m0_waitrequest); end
    tick();
    a.m0_read = 1'b0;
    rst = 1'b1;
    tick();
    n_cmp++; if (a.m0_readdatavalid !== 1'b0 || a.m0_readdata !== 32'h0) begin n_err++; $display("FAIL abort m0 outputs: got %b/%h expected 0/0", a.m0_readdatavalid, a.m0_readdata); end
    n_cmp++; if (a.check_done !== 1'b0 || a.check_id !== 32'h0 || a.check_ts !== 32'h0) begin n_err++; $display("FAIL abort check outputs: got %b/%h/%h expected 0/0/0", a.check_done, a.check_id, a.check_ts); end
    rst = 1'b0;
    last_win = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if (a.m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL abort stray valid k=%0d: got %b expected 0", k, a.m0_readdatavalid); end
      if (k == 5) begin
        n_cmp++; if (a.check_done !== 1'b1 || a.check_pass !== 1'b1) begin n_err++; $display("FAIL abort recheck: got done=%b pass=%b expected 1/1", a.check_done, a.check_pass); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_auto_check();
    test_single();
    test_round_robin();
    test_latency();
    test_mismatch();
    test_collide();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
